// File: rtl/debug_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : debug_ctrl_pkg
//  Description : Shared definitions for the debug sequencer. Contains the
//                command opcodes, the sequencer state encoding, the write
//                target encoding and a register-index legality helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package debug_ctrl_pkg;

    // Command opcodes carried on cmd_op
    localparam logic [2:0] OP_NOP        = 3'd0;
    localparam logic [2:0] OP_HALT       = 3'd1;
    localparam logic [2:0] OP_RUN        = 3'd2;
    localparam logic [2:0] OP_IMEM_WR    = 3'd3;
    localparam logic [2:0] OP_DMEM_WR    = 3'd4;
    localparam logic [2:0] OP_REG_WR     = 3'd5;
    localparam logic [2:0] OP_IMEM_BURST = 3'd6;
    localparam logic [2:0] OP_DMEM_BURST = 3'd7;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_BURST = 3'd2,
        ST_RUN   = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // Resource selected by the pending write
    typedef enum logic [1:0] {
        TGT_IMEM = 2'd0,
        TGT_DMEM = 2'd1,
        TGT_REG  = 2'd2
    } target_t;

    // x0 is hard-wired, and the index field is only five bits wide, so any
    // other address bit set means the host asked for something that does
    // not exist.
    function automatic logic reg_index_ok(input logic [31:0] addr);
        return (addr[4:0] != 5'd0) && (addr[31:5] == 27'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/run_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : run_timer
//  Description : Loadable down-counter used to step the core. Reports when
//                the remaining count is zero (free-run) or one (final step),
//                and provides the saturating count of run cycles including
//                the current one.
//  Ports       : clk, rst (async active-low), load/load_val (start a run),
//                tick (core ran this cycle), zero, last, elapsed
//  Revision    : 1.0 - initial release
// ============================================================================
module run_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         zero,
    output logic         last,
    output logic [W-1:0] elapsed
);

    logic [W-1:0] remaining;
    logic [W-1:0] elapsed_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            remaining <= '0;
            elapsed_q <= '0;
        end else if (load) begin
            remaining <= load_val;
            elapsed_q <= '0;
        end else if (tick) begin
            if (!zero) begin
                remaining <= remaining - W'(1);
            end
            elapsed_q <= elapsed;
        end
    end

    assign zero    = (remaining == '0);
    assign last    = (remaining == W'(1));
    // Counts the current cycle too, so a halt taken now reports it.
    assign elapsed = (&elapsed_q) ? elapsed_q : elapsed_q + W'(1);

endmodule
`default_nettype wire

// File: rtl/debug_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : debug_ctrl
//  Description : Host-facing debug sequencer for the single-cycle RISC-V
//                core. Consumes a valid/ready command stream and drives the
//                core reset, reset vector and debug write ports of imem,
//                dmem and the register file.
//  Ports       : clk, rst (async active-low)
//                cmd_*        command stream (valid/ready, op, addr, data)
//                rsp_*        response (valid/ready, err, data)
//                core_*       core run control and reset vector
//                debug_*      debug ownership, write strobes, addr, data
//  Revision    : 1.0 - initial release
// ============================================================================
module debug_ctrl
    import debug_ctrl_pkg::*;
#(
    parameter int          BURST_W = 16,
    parameter logic [31:0] RST_VEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_err,
    output logic [31:0] rsp_data,
    output logic        core_running,
    output logic        core_rst,
    output logic [31:0] rst_addr,
    output logic        debug_imem_oe,
    output logic        debug_dmem_oe,
    output logic        debug_reg_oe,
    output logic        debug_imem_we,
    output logic        debug_dmem_we,
    output logic        debug_reg_we,
    output logic [31:0] debug_imem_addr,
    output logic [31:0] debug_dmem_addr,
    output logic [31:0] debug_imem_data,
    output logic [31:0] debug_dmem_data,
    output logic [31:0] debug_reg_data,
    output logic [4:0]  debug_reg_ra,
    output logic [4:0]  debug_reg_rb
);

    localparam int PAD_W = 32 - BURST_W;

    state_t              state,      state_nxt;
    logic                halted,     halted_nxt;
    logic [31:0]         vec_q,      vec_nxt;
    target_t             tgt,        tgt_nxt;
    logic [31:0]         addr_q,     addr_nxt;
    logic [31:0]         data_q,     data_nxt;
    logic [BURST_W-1:0]  count_q,    count_nxt;
    logic [BURST_W-1:0]  beat_q,     beat_nxt;
    logic                beat_pend,  beat_pend_nxt;
    logic                main_err,   main_err_nxt;
    logic [31:0]         main_data,  main_data_nxt;
    // One-entry slot for NOP / illegal-op acknowledgements while running
    logic                side_valid, side_valid_nxt;
    logic                side_err,   side_err_nxt;

    logic                accept;
    logic                rsp_take;
    logic                stop;
    logic                wr_cycle;
    logic [BURST_W-1:0]  cmd_count;
    logic                cmd_count_hi;

    logic                tmr_load;
    logic                tmr_tick;
    logic                tmr_zero;
    logic                tmr_last;
    logic [BURST_W-1:0]  tmr_elapsed;

    assign accept       = cmd_valid & cmd_ready;
    assign rsp_take     = rsp_valid & rsp_ready;
    assign cmd_count    = cmd_data[BURST_W-1:0];
    assign cmd_count_hi = (cmd_data >> BURST_W) != 32'd0;
    assign tmr_tick     = (state == ST_RUN);

    run_timer #(
        .W (BURST_W)
    ) u_run_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (cmd_count),
        .tick     (tmr_tick),
        .zero     (tmr_zero),
        .last     (tmr_last),
        .elapsed  (tmr_elapsed)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            halted     <= 1'b1;
            vec_q      <= RST_VEC;
            tgt        <= TGT_IMEM;
            addr_q     <= '0;
            data_q     <= '0;
            count_q    <= '0;
            beat_q     <= '0;
            beat_pend  <= 1'b0;
            main_err   <= 1'b0;
            main_data  <= '0;
            side_valid <= 1'b0;
            side_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            halted     <= halted_nxt;
            vec_q      <= vec_nxt;
            tgt        <= tgt_nxt;
            addr_q     <= addr_nxt;
            data_q     <= data_nxt;
            count_q    <= count_nxt;
            beat_q     <= beat_nxt;
            beat_pend  <= beat_pend_nxt;
            main_err   <= main_err_nxt;
            main_data  <= main_data_nxt;
            side_valid <= side_valid_nxt;
            side_err   <= side_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Command ready
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready = 1'b0;
        case (state)
            ST_IDLE:  cmd_ready = 1'b1;
            ST_BURST: cmd_ready = ~beat_pend;
            ST_RUN:   cmd_ready = ~side_valid;
            default:  cmd_ready = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        halted_nxt     = halted;
        vec_nxt        = vec_q;
        tgt_nxt        = tgt;
        addr_nxt       = addr_q;
        data_nxt       = data_q;
        count_nxt      = count_q;
        beat_nxt       = beat_q;
        beat_pend_nxt  = beat_pend;
        main_err_nxt   = main_err;
        main_data_nxt  = main_data;
        side_valid_nxt = side_valid;
        side_err_nxt   = side_err;
        tmr_load       = 1'b0;
        stop           = 1'b0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    main_err_nxt  = 1'b0;
                    main_data_nxt = '0;
                    case (cmd_op)
                        OP_NOP, OP_HALT: begin
                            state_nxt = ST_RESP;
                        end
                        OP_RUN: begin
                            vec_nxt    = cmd_addr;
                            halted_nxt = 1'b0;
                            tmr_load   = 1'b1;
                            state_nxt  = ST_RUN;
                        end
                        OP_IMEM_WR, OP_DMEM_WR: begin
                            tgt_nxt   = (cmd_op == OP_IMEM_WR) ? TGT_IMEM : TGT_DMEM;
                            addr_nxt  = cmd_addr;
                            data_nxt  = cmd_data;
                            state_nxt = ST_WRITE;
                        end
                        OP_REG_WR: begin
                            if (reg_index_ok(cmd_addr)) begin
                                tgt_nxt   = TGT_REG;
                                addr_nxt  = cmd_addr;
                                data_nxt  = cmd_data;
                                state_nxt = ST_WRITE;
                            end else begin
                                main_err_nxt = 1'b1;
                                state_nxt    = ST_RESP;
                            end
                        end
                        default: begin
                            // IMEM_BURST / DMEM_BURST
                            if ((cmd_count == '0) || cmd_count_hi) begin
                                main_err_nxt = 1'b1;
                                state_nxt    = ST_RESP;
                            end else begin
                                tgt_nxt       = (cmd_op == OP_IMEM_BURST) ? TGT_IMEM : TGT_DMEM;
                                addr_nxt      = cmd_addr;
                                count_nxt     = cmd_count;
                                beat_nxt      = '0;
                                beat_pend_nxt = 1'b0;
                                state_nxt     = ST_BURST;
                            end
                        end
                    endcase
                end
            end

            ST_WRITE: begin
                main_data_nxt = 32'd1;
                state_nxt     = ST_RESP;
            end

            ST_BURST: begin
                if (beat_pend) begin
                    // Strobe cycle: advance to the next word slot.
                    beat_pend_nxt = 1'b0;
                    addr_nxt      = addr_q + 32'd4;
                    beat_nxt      = beat_q + BURST_W'(1);
                    if ((beat_q + BURST_W'(1)) == count_q) begin
                        main_data_nxt = {{PAD_W{1'b0}}, count_q};
                        state_nxt     = ST_RESP;
                    end
                end else if (accept) begin
                    data_nxt      = cmd_data;
                    beat_pend_nxt = 1'b1;
                end
            end

            ST_RUN: begin
                if (rsp_take) begin
                    side_valid_nxt = 1'b0;
                end
                if (accept) begin
                    case (cmd_op)
                        OP_HALT: stop = 1'b1;
                        OP_NOP: begin
                            side_valid_nxt = 1'b1;
                            side_err_nxt   = 1'b0;
                        end
                        default: begin
                            side_valid_nxt = 1'b1;
                            side_err_nxt   = 1'b1;
                        end
                    endcase
                end
                // Step expiry and HALT in the same cycle fold into one halt.
                if (!tmr_zero && tmr_last) begin
                    stop = 1'b1;
                end
                if (stop) begin
                    halted_nxt    = 1'b1;
                    main_err_nxt  = 1'b0;
                    main_data_nxt = {{PAD_W{1'b0}}, tmr_elapsed};
                    state_nxt     = ST_RESP;
                end
            end

            ST_RESP: begin
                // A side acknowledgement still queued is presented first.
                if (rsp_take) begin
                    if (side_valid) begin
                        side_valid_nxt = 1'b0;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rsp_valid = side_valid | (state == ST_RESP);
    assign rsp_err   = side_valid ? side_err : ((state == ST_RESP) & main_err);
    assign rsp_data  = side_valid ? 32'd0 : ((state == ST_RESP) ? main_data : 32'd0);

    assign core_rst      = halted;
    assign core_running  = ~halted;
    assign rst_addr      = vec_q;
    assign debug_imem_oe = halted;
    assign debug_dmem_oe = halted;
    assign debug_reg_oe  = halted;

    assign wr_cycle      = (state == ST_WRITE) | ((state == ST_BURST) & beat_pend);
    assign debug_imem_we = wr_cycle & (tgt == TGT_IMEM);
    assign debug_dmem_we = wr_cycle & (tgt == TGT_DMEM);
    assign debug_reg_we  = wr_cycle & (tgt == TGT_REG);

    assign debug_imem_addr = addr_q;
    assign debug_dmem_addr = addr_q;
    assign debug_imem_data = data_q;
    assign debug_dmem_data = data_q;
    assign debug_reg_data  = data_q;
    assign debug_reg_ra    = addr_q[4:0];
    assign debug_reg_rb    = addr_q[4:0];

endmodule
`default_nettype wire

// File: tb/tb_debug_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_debug_ctrl
//  Description : Self-checking bench for debug_ctrl. Directed scenarios
//                followed by randomized commands checked against a
//                behavioural model of expected writes and responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_ctrl;
    import debug_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [31:0] cmd_addr = 32'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_err;
    logic [31:0] rsp_data;
    logic        core_running, core_rst;
    logic [31:0] rst_addr;
    logic        debug_imem_oe, debug_dmem_oe, debug_reg_oe;
    logic        debug_imem_we, debug_dmem_we, debug_reg_we;
    logic [31:0] debug_imem_addr, debug_dmem_addr;
    logic [31:0] debug_imem_data, debug_dmem_data, debug_reg_data;
    logic [4:0]  debug_reg_ra, debug_reg_rb;

    debug_ctrl #(
        .BURST_W (16),
        .RST_VEC (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_op          (cmd_op),
        .cmd_addr        (cmd_addr),
        .cmd_data        (cmd_data),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_err         (rsp_err),
        .rsp_data        (rsp_data),
        .core_running    (core_running),
        .core_rst        (core_rst),
        .rst_addr        (rst_addr),
        .debug_imem_oe   (debug_imem_oe),
        .debug_dmem_oe   (debug_dmem_oe),
        .debug_reg_oe    (debug_reg_oe),
        .debug_imem_we   (debug_imem_we),
        .debug_dmem_we   (debug_dmem_we),
        .debug_reg_we    (debug_reg_we),
        .debug_imem_addr (debug_imem_addr),
        .debug_dmem_addr (debug_dmem_addr),
        .debug_imem_data (debug_imem_data),
        .debug_dmem_data (debug_dmem_data),
        .debug_reg_data  (debug_reg_data),
        .debug_reg_ra    (debug_reg_ra),
        .debug_reg_rb    (debug_reg_rb)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Observed write log, filled by the monitor only
    logic [1:0]  wl_kind [0:1023];
    logic [31:0] wl_addr [0:1023];
    logic [31:0] wl_data [0:1023];
    int wl_n       = 0;
    int multi_we   = 0;
    int we_running = 0;
    int low_cycles = 0;
    int wl_rd      = 0;

    always @(negedge clk) begin
        int nwe;
        nwe = int'(debug_imem_we) + int'(debug_dmem_we) + int'(debug_reg_we);
        if (nwe > 1) multi_we++;
        if (nwe != 0 && core_rst !== 1'b1) we_running++;
        if (core_rst === 1'b0) low_cycles++;
        if (debug_imem_we) begin
            wl_kind[wl_n % 1024] = 2'd0;
            wl_addr[wl_n % 1024] = debug_imem_addr;
            wl_data[wl_n % 1024] = debug_imem_data;
            wl_n++;
        end
        if (debug_dmem_we) begin
            wl_kind[wl_n % 1024] = 2'd1;
            wl_addr[wl_n % 1024] = debug_dmem_addr;
            wl_data[wl_n % 1024] = debug_dmem_data;
            wl_n++;
        end
        if (debug_reg_we) begin
            wl_kind[wl_n % 1024] = 2'd2;
            wl_addr[wl_n % 1024] = {22'd0, debug_reg_rb, debug_reg_ra};
            wl_data[wl_n % 1024] = debug_reg_data;
            wl_n++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
        logic ok;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        chk("cmd_accepted", ok, 1);
    endtask

    task automatic get_rsp(output logic err, output logic [31:0] d);
        logic ok;
        ok        = 1'b0;
        err       = 1'bx;
        d         = 'x;
        rsp_ready = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                ok  = 1'b1;
                err = rsp_err;
                d   = rsp_data;
            end
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b0;
        chk("rsp_arrived", ok, 1);
    endtask

    task automatic expect_write(input string tag, input logic [1:0] k,
                                input logic [31:0] a, input logic [31:0] d);
        logic present;
        present = (wl_n > wl_rd);
        chk({tag, "_present"}, present, 1);
        if (present) begin
            chk({tag, "_kind"}, wl_kind[wl_rd % 1024], k);
            chk({tag, "_addr"}, wl_addr[wl_rd % 1024], a);
            chk({tag, "_data"}, wl_data[wl_rd % 1024], d);
            wl_rd++;
        end
    endtask

    task automatic no_extra_writes(input string tag);
        chk({tag, "_write_count"}, wl_n, wl_rd);
        wl_rd = wl_n;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        e;
        logic [31:0] r;
        int          lc0;
        int          sel, cnt, n;
        logic [31:0] a, d, base;
        logic [31:0] beats [0:7];
        logic        valid;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("rst_core_rst", core_rst, 1);
        chk("rst_core_running", core_running, 0);
        chk("rst_oe", {debug_imem_oe, debug_dmem_oe, debug_reg_oe}, 3'b111);
        chk("rst_we", {debug_imem_we, debug_dmem_we, debug_reg_we}, 3'b000);
        chk("rst_rst_addr", rst_addr, 32'h0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_data", rsp_data, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_ready", cmd_ready, 1);

        // ---------------- IMEM burst of 3 ----------------
        send(OP_IMEM_BURST, 32'h100, 32'd3);
        send(3'($urandom_range(0, 7)), 32'h0, 32'h13);
        send(3'($urandom_range(0, 7)), 32'h0, 32'h93);
        send(3'($urandom_range(0, 7)), 32'h0, 32'h113);
        get_rsp(e, r);
        chk("burst3_err", e, 0);
        chk("burst3_data", r, 3);
        expect_write("burst3_w0", 2'd0, 32'h100, 32'h13);
        expect_write("burst3_w1", 2'd0, 32'h104, 32'h93);
        expect_write("burst3_w2", 2'd0, 32'h108, 32'h113);
        no_extra_writes("burst3");

        // ---------------- register writes ----------------
        send(OP_REG_WR, 32'd5, 32'hDEAD_BEEF);
        get_rsp(e, r);
        chk("regwr5_err", e, 0);
        chk("regwr5_data", r, 1);
        expect_write("regwr5", 2'd2, {22'd0, 5'd5, 5'd5}, 32'hDEAD_BEEF);
        no_extra_writes("regwr5");

        send(OP_REG_WR, 32'd0, 32'h1234_5678);
        get_rsp(e, r);
        chk("regwr0_err", e, 1);
        no_extra_writes("regwr0");

        send(OP_REG_WR, 32'h25, 32'h1);
        get_rsp(e, r);
        chk("regwr_hi_err", e, 1);
        no_extra_writes("regwr_hi");

        // ---------------- stepped run of 10 ----------------
        lc0 = low_cycles;
        send(OP_RUN, 32'h100, 32'd10);
        chk("run10_core_rst", core_rst, 0);
        chk("run10_running", core_running, 1);
        chk("run10_oe", debug_imem_oe, 0);
        chk("run10_vec", rst_addr, 32'h100);
        get_rsp(e, r);
        chk("run10_err", e, 0);
        chk("run10_data", r, 10);
        chk("run10_low_cycles", low_cycles - lc0, 10);
        chk("run10_halted", core_rst, 1);
        chk("run10_oe_back", debug_dmem_oe, 1);

        // ---------------- free run, illegal write, HALT after 7 ----------------
        lc0 = low_cycles;
        send(OP_RUN, 32'h200, 32'd0);
        send(OP_DMEM_WR, 32'h40, 32'h55);
        get_rsp(e, r);
        chk("fr_illegal_err", e, 1);
        chk("fr_still_running", core_running, 1);
        repeat (4) @(posedge clk);
        #1;
        send(OP_HALT, 32'h0, 32'h0);
        get_rsp(e, r);
        chk("fr_halt_err", e, 0);
        chk("fr_halt_data", r, 7);
        chk("fr_low_cycles", low_cycles - lc0, 7);
        chk("fr_halted", core_rst, 1);
        no_extra_writes("fr");

        // ---------------- NOP while running, back-pressure ----------------
        lc0 = low_cycles;
        send(OP_RUN, 32'h80, 32'd0);
        send(OP_NOP, 32'h0, 32'h0);
        chk("nop_backpressure", cmd_ready, 0);
        get_rsp(e, r);
        chk("nop_run_err", e, 0);
        chk("nop_run_running", core_running, 1);
        send(OP_HALT, 32'h0, 32'h0);
        get_rsp(e, r);
        chk("nop_halt_data", r, low_cycles - lc0);
        chk("nop_halted", core_rst, 1);

        // ---------------- HALT coincides with final step ----------------
        lc0 = low_cycles;
        send(OP_RUN, 32'h0, 32'd3);
        repeat (2) @(posedge clk);
        #1;
        send(OP_HALT, 32'h0, 32'h0);
        get_rsp(e, r);
        chk("coinc_err", e, 0);
        chk("coinc_data", r, 3);
        chk("coinc_low_cycles", low_cycles - lc0, 3);
        repeat (3) @(posedge clk);
        #1;
        chk("coinc_single_rsp", rsp_valid, 0);
        chk("coinc_idle", cmd_ready, 1);

        // ---------------- reset during a burst ----------------
        send(OP_IMEM_BURST, 32'h300, 32'd4);
        send(OP_NOP, 32'h0, 32'hA1);
        send(OP_NOP, 32'h0, 32'hA2);
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_core_rst", core_rst, 1);
        chk("abort_we", {debug_imem_we, debug_dmem_we, debug_reg_we}, 3'b000);
        chk("abort_rsp_valid", rsp_valid, 0);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_rsp", rsp_valid, 0);
        chk("abort_idle", cmd_ready, 1);
        chk("abort_vec", rst_addr, 32'h0);
        expect_write("abort_w0", 2'd0, 32'h300, 32'hA1);
        expect_write("abort_w1", 2'd0, 32'h304, 32'hA2);
        no_extra_writes("abort");

        send(OP_DMEM_BURST, 32'h0, 32'd0);
        get_rsp(e, r);
        chk("burst0_err", e, 1);
        no_extra_writes("burst0");

        send(OP_IMEM_BURST, 32'h0, 32'h0001_0002);
        get_rsp(e, r);
        chk("burst_hi_err", e, 1);
        no_extra_writes("burst_hi");

        // ---------------- randomized commands vs model ----------------
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 6);
            case (sel)
                0, 1: begin
                    a = $urandom;
                    d = $urandom;
                    send((sel == 0) ? OP_IMEM_WR : OP_DMEM_WR, a, d);
                    get_rsp(e, r);
                    chk("rnd_wr_err", e, 0);
                    chk("rnd_wr_data", r, 1);
                    expect_write("rnd_wr", 2'(sel), a, d);
                end
                2: begin
                    a = 32'($urandom_range(0, 31));
                    if ($urandom_range(0, 3) == 0) a = a + (32'd1 << $urandom_range(5, 31));
                    d = $urandom;
                    valid = (a >= 32'd1) && (a <= 32'd31);
                    send(OP_REG_WR, a, d);
                    get_rsp(e, r);
                    chk("rnd_reg_err", e, !valid);
                    if (valid) expect_write("rnd_reg", 2'd2, {22'd0, a[4:0], a[4:0]}, d);
                end
                3, 4: begin
                    cnt  = $urandom_range(0, 5);
                    d    = 32'(cnt);
                    if ($urandom_range(0, 5) == 0) d = d + (32'd1 << $urandom_range(16, 31));
                    base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
                    valid = (d >= 32'd1) && (d < 32'd65536);
                    send((sel == 3) ? OP_IMEM_BURST : OP_DMEM_BURST, base, d);
                    if (valid) begin
                        for (int k = 0; k < cnt; k++) begin
                            beats[k] = $urandom;
                            send(3'($urandom_range(0, 7)), $urandom, beats[k]);
                        end
                    end
                    get_rsp(e, r);
                    chk("rnd_burst_err", e, !valid);
                    chk("rnd_burst_data", r, valid ? 32'(cnt) : 32'd0);
                    if (valid) begin
                        for (int k = 0; k < cnt; k++) begin
                            expect_write("rnd_burst", (sel == 3) ? 2'd0 : 2'd1,
                                         base + 32'(4 * k), beats[k]);
                        end
                    end
                end
                5: begin
                    n   = $urandom_range(1, 12);
                    a   = $urandom;
                    lc0 = low_cycles;
                    send(OP_RUN, a, 32'(n));
                    chk("rnd_run_vec", rst_addr, a);
                    get_rsp(e, r);
                    chk("rnd_run_err", e, 0);
                    chk("rnd_run_data", r, 32'(n));
                    chk("rnd_run_low", low_cycles - lc0, n);
                    chk("rnd_run_halted", core_rst, 1);
                end
                default: begin
                    send(OP_NOP, $urandom, $urandom);
                    get_rsp(e, r);
                    chk("rnd_nop_err", e, 0);
                    chk("rnd_nop_data", r, 0);
                end
            endcase
            no_extra_writes("rnd");
        end

        chk("single_we_per_cycle", multi_we, 0);
        chk("we_only_when_halted", we_running, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
